// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - tracks a 4-bit comparator's results: |A-B|, outcome counters, equal-run lock, consistency error
module cmp_result_tracker #(
  parameter int CNT_W  = 8,
  parameter int EQ_RUN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic             l,
  input  logic             g,
  input  logic             e,
  input  logic             clr,
  output logic             out_valid,
  output logic [3:0]       diff,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             match,
  output logic             err
);

  localparam logic [1:0]       ST_IDLE    = 2'd0;
  localparam logic [1:0]       ST_TRACK   = 2'd1;
  localparam logic [1:0]       ST_LOCKED  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [3:0]       STREAK_MAX = 4'hF;
  localparam logic [3:0]       RUN_TGT    = 4'(EQ_RUN);

  logic             armed_q;
  logic [1:0]       state_q, state_d;
  logic [3:0]       streak_q, streak_d;
  logic [CNT_W-1:0] lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic             err_q, err_d;
  logic             ov_q, ov_d;
  logic [3:0]       diff_q, diff_d;
  logic             accept, consistent;
  logic [3:0]       abs_diff;

  always_comb begin
    accept     = in_valid & armed_q & ~clr;
    consistent = ({l, g, e} == {A < B, A > B, A == B});
    abs_diff   = (A >= B) ? (A - B) : (B - A);

    state_d  = state_q;
    streak_d = streak_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    err_d    = err_q;
    ov_d     = 1'b0;
    diff_d   = diff_q;

    if (clr) begin
      state_d  = ST_IDLE;
      streak_d = 4'd0;
      lt_d     = '0;
      gt_d     = '0;
      eq_d     = '0;
      err_d    = 1'b0;
    end else if (accept) begin
      ov_d   = 1'b1;
      diff_d = abs_diff;
      if (!consistent) begin
        err_d    = 1'b1;
        streak_d = 4'd0;
      end else begin
        if (l && lt_q != CNT_MAX) lt_d = lt_q + 1'b1;
        if (g && gt_q != CNT_MAX) gt_d = gt_q + 1'b1;
        if (e && eq_q != CNT_MAX) eq_d = eq_q + 1'b1;
        if (e) streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        else   streak_d = 4'd0;
      end
      // Leaving LOCKED always zeroes the streak, so the threshold alone picks the next state.
      state_d = (streak_d >= RUN_TGT) ? ST_LOCKED : ST_TRACK;
    end
  end

  // armed_q delays acceptance to the second rising edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      state_q  <= ST_IDLE;
      streak_q <= 4'd0;
      lt_q     <= '0;
      gt_q     <= '0;
      eq_q     <= '0;
      err_q    <= 1'b0;
      ov_q     <= 1'b0;
      diff_q   <= 4'd0;
    end else begin
      armed_q  <= 1'b1;
      state_q  <= state_d;
      streak_q <= streak_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      err_q    <= err_d;
      ov_q     <= ov_d;
      diff_q   <= diff_d;
    end
  end

  assign out_valid = ov_q;
  assign diff      = diff_q;
  assign lt_cnt    = lt_q;
  assign gt_cnt    = gt_q;
  assign eq_cnt    = eq_q;
  assign match     = (state_q == ST_LOCKED);
  assign err       = err_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb/tb_cmp_result_tracker.sv - directed bench with a behavioural model checked every cycle
module tb_cmp_result_tracker;

  localparam int EQ_RUN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] a_s = 4'd0;
  logic [3:0] b_s = 4'd0;
  logic       l_s = 1'b0, g_s = 1'b0, e_s = 1'b0;

  logic       ov, mt, er, ov2, mt2, er2;
  logic [3:0] df, df2;
  logic [7:0] lt, gt, eq;
  logic [1:0] lt2, gt2, eq2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmp_result_tracker #(.CNT_W(8), .EQ_RUN(EQ_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a_s), .B(b_s),
    .l(l_s), .g(g_s), .e(e_s), .clr(clr), .out_valid(ov), .diff(df),
    .lt_cnt(lt), .gt_cnt(gt), .eq_cnt(eq), .match(mt), .err(er)
  );

  cmp_result_tracker #(.CNT_W(2), .EQ_RUN(EQ_RUN)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a_s), .B(b_s),
    .l(l_s), .g(g_s), .e(e_s), .clr(clr), .out_valid(ov2), .diff(df2),
    .lt_cnt(lt2), .gt_cnt(gt2), .eq_cnt(eq2), .match(mt2), .err(er2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: true (unbounded) counts and equal-run length; outputs derived by saturation/threshold.
  bit m_armed = 0, m_ov = 0, m_err = 0;
  int m_diff = 0, m_lt = 0, m_gt = 0, m_eq = 0, m_run = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_armed <= 0; m_ov <= 0; m_err <= 0;
      m_diff <= 0; m_lt <= 0; m_gt <= 0; m_eq <= 0; m_run <= 0;
    end else begin
      m_armed <= 1;
      m_ov    <= 0;
      if (clr) begin
        m_lt <= 0; m_gt <= 0; m_eq <= 0; m_run <= 0; m_err <= 0;
      end else if (in_valid && m_armed) begin
        m_ov   <= 1;
        m_diff <= (a_s >= b_s) ? int'(a_s) - int'(b_s) : int'(b_s) - int'(a_s);
        if (l_s != (a_s < b_s) || g_s != (a_s > b_s) || e_s != (a_s == b_s)) begin
          m_err <= 1;
          m_run <= 0;
        end else begin
          m_lt  <= m_lt + int'(l_s);
          m_gt  <= m_gt + int'(g_s);
          m_eq  <= m_eq + int'(e_s);
          m_run <= e_s ? m_run + 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", int'(ov), int'(m_ov));
    check("diff", int'(df), m_diff);
    check("lt_cnt", int'(lt), sat(m_lt, 255));
    check("gt_cnt", int'(gt), sat(m_gt, 255));
    check("eq_cnt", int'(eq), sat(m_eq, 255));
    check("match", int'(mt), int'(m_run >= EQ_RUN));
    check("err", int'(er), int'(m_err));
    check("lt_cnt_w2", int'(lt2), sat(m_lt, 3));
    check("gt_cnt_w2", int'(gt2), sat(m_gt, 3));
    check("eq_cnt_w2", int'(eq2), sat(m_eq, 3));
    check("match_w2", int'(mt2), int'(m_run >= EQ_RUN));
  end

  task automatic set(input int a, input int b, input logic [2:0] lge, input logic v, input logic c);
    a_s = 4'(a); b_s = 4'(b); {l_s, g_s, e_s} = lge; in_valid = v; clr = c;
  endtask

  task automatic set_ok(input int a, input int b);
    set(a, b, {a < b, a > b, a == b}, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_clr();
    set(0, 0, 3'b000, 1'b0, 1'b1);
    step();
    set(0, 0, 3'b000, 1'b0, 1'b0);
  endtask

  int lt2_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    repeat (3) step();
    check("rst_out_valid", int'(ov), 0);
    check("rst_diff", int'(df), 0);
    check("rst_match", int'(mt), 0);

    // Basic outcomes; first sample held across the unarmed edge after release.
    rst_n = 1'b1;
    set(1, 2, 3'b100, 1'b1, 1'b0);
    step(); check("first_edge_not_accepted", int'(ov), 0);
    step(); check("s1_valid", int'(ov), 1); check("s1_diff", int'(df), 1); check("s1_lt", int'(lt), 1);
    set(5, 0, 3'b010, 1'b1, 1'b0);
    step(); check("s2_diff", int'(df), 5); check("s2_gt", int'(gt), 1);
    set(3, 3, 3'b001, 1'b1, 1'b0);
    step(); check("s3_diff", int'(df), 0); check("s3_eq", int'(eq), 1); check("s3_err", int'(er), 0);
    set(9, 9, 3'b001, 1'b0, 1'b0);
    step(); check("idle_valid", int'(ov), 0); check("idle_diff_hold", int'(df), 0);

    // Equal run locks, persists, then unlocks.
    do_clr();
    step(); check("clr_lt", int'(lt), 0);
    set_ok(1, 1); step();
    set_ok(2, 2); step(); check("run2_match", int'(mt), 0);
    set_ok(3, 3); step(); check("run3_match", int'(mt), 1); check("run3_valid", int'(ov), 1);
    set_ok(4, 4); step(); check("run4_match", int'(mt), 1);
    set_ok(8, 5); step(); check("unlock_match", int'(mt), 0); check("unlock_gt", int'(gt), 1);

    // Inconsistent outcome bits set sticky err.
    set(4, 9, 3'b010, 1'b1, 1'b0);
    step(); check("bad_err", int'(er), 1); check("bad_gt", int'(gt), 1); check("bad_diff", int'(df), 5);
    for (int i = 0; i < 10; i++) begin
      set_ok(i, (i * 7) % 16); step();
    end
    set(0, 0, 3'b000, 1'b0, 1'b0);
    step(); check("err_sticky", int'(er), 1);
    do_clr();
    step(); check("err_cleared", int'(er), 0);

    // Saturation of the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      set_ok(i, i + 1); step();
      check("w2_lt_sat", int'(lt2), lt2_exp[i]);
    end
    check("w8_lt", int'(lt), 5);

    // Async reset mid-cycle discards a partial run.
    do_clr();
    set_ok(3, 3); step(); step();
    set(0, 0, 3'b000, 1'b0, 1'b0);
    check("pre_rst_eq", int'(eq), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_eq", int'(eq), 0); check("async_valid", int'(ov), 0);
    check("async_match", int'(mt), 0); check("async_err", int'(er), 0);
    step();
    rst_n = 1'b1;
    set_ok(6, 6);
    step(); check("rel_unarmed", int'(ov), 0);
    step(); step(); check("rel_run2_match", int'(mt), 0);
    step(); check("rel_run3_match", int'(mt), 1);

    // clr wins over in_valid.
    set(2, 10, 3'b100, 1'b1, 1'b1);
    step(); check("clr_pri_valid", int'(ov), 0); check("clr_pri_lt", int'(lt), 0); check("clr_pri_match", int'(mt), 0);
    set(0, 0, 3'b000, 1'b0, 1'b0);
    step(); check("clr_pri_after", int'(ov), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
